// File: rtl/recursive_mult_seq.sv
// Sequential unsigned multiplier built from 4x4 nibble sub-products,
// one sub-product per cycle, with an optional truncated low-order mode.
module recursive_mult_seq #(
  parameter int W     = 8,
  parameter int TRUNC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y,
  output logic           y_approx
);

  localparam int NB  = W / 4;
  localparam int NSP = NB * NB;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW  = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           ap_q, ap_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [IW-1:0]  i_q, i_d;
  logic [IW-1:0]  j_q, j_d;

  logic [SW-1:0]  ij;
  logic           gate;
  logic           last;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [7:0]     sp;
  logic [2*W-1:0] sp_ext;

  // Truncated sub-products get zeroed operands so the 4x4 unit stays quiet.
  always_comb begin
    ij     = SW'(i_q) + SW'(j_q);
    gate   = ap_q && (ij < SW'(TRUNC));
    a_nib  = gate ? 4'd0 : 4'(a_q >> {i_q, 2'b00});
    b_nib  = gate ? 4'd0 : 4'(b_q >> {j_q, 2'b00});
    sp     = {4'd0, a_nib} * {4'd0, b_nib};
    sp_ext = '0;
    sp_ext[7:0] = sp;
    sp_ext = sp_ext << {ij, 2'b00};
    last   = (i_q == IW'(NB - 1)) &&
             (j_q == IW'(NB - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ap_d    = ap_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          ap_d    = approx;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + sp_ext;
        if (i_q == IW'(NB - 1)) begin
          i_d = '0;
          j_d = j_q + IW'(1);
        end else begin
          i_d = i_q + IW'(1);
        end
        if (last) begin
          i_d     = '0;
          j_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ap_q    <= 1'b0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ap_q    <= ap_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = acc_q;
  assign y_approx  = ap_q;

endmodule
